// File: rtl/relu_frame_seq.sv
// relu_frame_seq: sequences the LANES-wide ReLU datapath over one frame of
// ROWS input beats, with a start/done protocol, valid/ready on both sides,
// a one-stage output register, last-beat marking and a per-frame count of
// negative (clamped) lanes.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start / busy / done     frame control (start sampled only in IDLE)
//   in_valid/in_ready/in_data     input beats, lane k at [k*IN_W +: IN_W]
//   out_valid/out_ready/out_data  output beats, lane k at [k*(IN_W-1) +: IN_W-1]
//   out_last                marks the ROWS-th output beat of a frame
//   zero_count              negative lanes seen this frame, saturating

module relu_lane #(
  parameter int IN_W = 8
)(
  input  logic [IN_W-1:0] din,
  output logic [IN_W-2:0] dout,
  output logic            neg
);
  assign neg  = din[IN_W-1];
  assign dout = din[IN_W-2:0] & {(IN_W-1){~din[IN_W-1]}};
endmodule

module relu_frame_seq #(
  parameter int LANES = 32,
  parameter int IN_W  = 8,
  parameter int ROWS  = 16,
  parameter int CNT_W = 10
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*IN_W-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*(IN_W-1)-1:0]   out_data,
  output logic                        out_last,
  output logic [CNT_W-1:0]            zero_count
);
  localparam int OW = IN_W - 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state;
  logic [LANES-1:0][IN_W-1:0] lane_in;
  logic [LANES-1:0][OW-1:0]   lane_out;
  logic [LANES-1:0][OW-1:0]   dq;
  logic [LANES-1:0]           neg;
  logic [RW-1:0]              in_cnt, out_cnt;
  logic [CNT_W:0]             zsum;
  logic [CNT_W-1:0]           zsat;
  logic                       in_hs, out_hs;

  assign lane_in = in_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    relu_lane #(.IN_W(IN_W)) u_lane (
      .din  (lane_in[k]),
      .dout (lane_out[k]),
      .neg  (neg[k])
    );
  end

  // Register can take a new beat when empty or when it drains this cycle.
  assign in_ready = (state == RUN) & (~out_valid | out_ready);
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign out_data = dq;
  assign out_last = out_valid & (out_cnt == LAST);

  // One extra bit catches overflow so the count saturates instead of wrapping.
  always_comb begin
    zsum = {1'b0, zero_count};
    for (int k = 0; k < LANES; k++)
      zsum = zsum + {{CNT_W{1'b0}}, neg[k]};
    zsat = zsum[CNT_W] ? '1 : zsum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      dq         <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      zero_count <= '0;
    end else begin
      done <= 1'b0;

      // Input handshake wins over drain: a same-cycle pair replaces the
      // register contents with no bubble.
      if (in_hs) begin
        dq        <= lane_out;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      if (out_hs)
        out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;

      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          busy       <= 1'b1;
          in_cnt     <= '0;
          out_cnt    <= '0;
          zero_count <= '0;
        end
        RUN: if (in_hs) begin
          zero_count <= zsat;
          if (in_cnt == LAST) begin
            in_cnt <= '0;
            state  <= FLUSH;
          end else begin
            in_cnt <= in_cnt + 1'b1;
          end
        end
        FLUSH: if (out_hs && out_cnt == LAST) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
